// File: rtl/fetch_unit.sv
// Fetch sequencer: PC -> imem word read -> IR, valid/ack to control; optional FETCH_TIMEOUT_EN retry timer.
// Latency: REQ at cycle 0, earliest ir_valid at cycle 2 (mem_ready in the cycle after REQ).
// Backpressure: HOLD keeps ir_out/ir_valid until ir_ack; no new request issues while holding.
module fetch_unit #(
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 16
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              run,
   input  logic [31:0]       pc_in,
   output logic              pc_increment,
   output logic              pc_load,
   output logic [31:0]       pc_target,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   input  logic              mem_ready,
   input  logic [31:0]       mem_data,
   output logic [31:0]       ir_out,
   output logic              ir_valid,
   input  logic              ir_ack,
   output logic              fetch_error
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] fetch_addr;
   logic        squash;
   logic        load_ir;
   logic        drop_ir;
   logic        retry;
   logic        timed_out;
   logic        unused_bits;

   always_comb begin
      state_nxt    = state;
      mem_read     = 1'b0;
      mem_addr     = '0;
      pc_increment = 1'b0;
      pc_load      = (state != IDLE) && branch_taken;
      pc_target    = (state != IDLE) ? branch_target : 32'd0;
      load_ir      = 1'b0;
      drop_ir      = 1'b0;
      retry        = 1'b0;
      case (state)
         IDLE: begin
            if (run) state_nxt = REQ;
         end
         REQ: begin
            // A redirect here cancels the read before memory ever sees it.
            mem_addr = pc_in[ADDR_W-1:0];
            mem_read = !branch_taken;
            if (branch_taken) state_nxt = run ? REQ : IDLE;
            else              state_nxt = WAIT;
         end
         WAIT: begin
            mem_addr = fetch_addr[ADDR_W-1:0];
            mem_read = 1'b1;
            if (mem_ready) begin
               if (branch_taken) begin
                  state_nxt = run ? REQ : IDLE;
               end else begin
                  load_ir      = 1'b1;
                  pc_increment = 1'b1;
                  state_nxt    = HOLD;
               end
            end else if (branch_taken) begin
               state_nxt = DRAIN;
            end else if (timed_out) begin
               mem_read  = 1'b0;
               retry     = 1'b1;
               state_nxt = REQ;
            end
         end
         HOLD: begin
            if (branch_taken || ir_ack) begin
               drop_ir   = 1'b1;
               state_nxt = run ? REQ : IDLE;
            end
         end
         DRAIN: begin
            if (mem_ready) begin
               state_nxt = run ? REQ : IDLE;
            end else if (timed_out) begin
               retry     = 1'b1;
               state_nxt = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state      <= IDLE;
         fetch_addr <= '0;
         ir_out     <= '0;
         ir_valid   <= 1'b0;
         squash     <= 1'b0;
      end else begin
         state  <= state_nxt;
         // squash marks an outstanding response that belongs to a redirected fetch.
         squash <= (state_nxt == DRAIN);
         if (state == REQ && !branch_taken) fetch_addr <= pc_in;
         if (load_ir && !squash) begin
            ir_out   <= mem_data;
            ir_valid <= 1'b1;
         end else if (drop_ir) begin
            ir_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_TIMEOUT_EN
   logic [7:0] wait_cnt;
   logic       error_q;

   always_ff @(posedge clock) begin
      if (clear) begin
         wait_cnt <= '0;
         error_q  <= 1'b0;
      end else begin
         if (state_nxt != state)                 wait_cnt <= '0;
         else if (state == WAIT || state == DRAIN) wait_cnt <= wait_cnt + 8'd1;
         if (retry) error_q <= 1'b1;
      end
   end

   // wait_cnt is 0 in the first WAIT/DRAIN cycle, so this fires on the TIMEOUT-th cycle.
   assign timed_out   = (state == WAIT || state == DRAIN) && (wait_cnt == 8'(TIMEOUT - 1));
   assign fetch_error = error_q;
   assign unused_bits = ^{pc_in[31:ADDR_W], fetch_addr[31:ADDR_W]};
`else
   assign timed_out   = 1'b0;
   assign fetch_error = 1'b0;
   assign unused_bits = ^{pc_in[31:ADDR_W], fetch_addr[31:ADDR_W], retry};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run scored against an instruction-stream model.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        clear, run, branch_taken, mem_ready, ir_ack;
   logic [31:0] pc_in, branch_target, mem_data;
   logic        pc_increment, pc_load, mem_read, ir_valid, fetch_error;
   logic [31:0] pc_target, ir_out;
   logic [8:0]  mem_addr;
   logic [31:0] pc_reg = 32'd0;
   logic        pc_force = 1'b0;
   logic [31:0] pc_force_val = 32'd0;
   int          errors = 0;
   int          checks = 0;

   always #5 clock = ~clock;

   // Environment PC register: increments or loads at the same edge as the DUT pulses.
   always @(posedge clock) begin
      if (pc_force)          pc_reg <= pc_force_val;
      else if (pc_increment) pc_reg <= pc_reg + 32'd1;
      else if (pc_load)      pc_reg <= pc_target;
   end
   assign pc_in = pc_reg;

   fetch_unit #(.ADDR_W(9), .TIMEOUT(16)) dut (
      .clock(clock), .clear(clear), .run(run), .pc_in(pc_in),
      .pc_increment(pc_increment), .pc_load(pc_load), .pc_target(pc_target),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_ready(mem_ready), .mem_data(mem_data),
      .ir_out(ir_out), .ir_valid(ir_valid), .ir_ack(ir_ack), .fetch_error(fetch_error)
   );

   function automatic logic [31:0] memf(input logic [8:0] a);
      return ({23'd0, a} * 32'h0001_0001) ^ 32'hC3A5_0F00;
   endfunction

   task automatic cyc();
      @(negedge clock);
   endtask

   // Clears the DUT, seeds the PC and returns at the negedge of the first REQ cycle.
   task automatic restart(input logic [31:0] pc);
      cyc(); clear = 1'b1; run = 1'b0; ir_ack = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
      pc_force = 1'b1; pc_force_val = pc;
      cyc(); clear = 1'b0; pc_force = 1'b0; run = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      cyc(); cyc(); #1;
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
      checks++; if (pc_increment !== 1'b0) begin errors++; $display("FAIL reset_pc_increment: got %b want 0", pc_increment); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid: got %b want 0", ir_valid); end
      checks++; if (ir_out !== 32'd0) begin errors++; $display("FAIL reset_ir_out: got %h want 0", ir_out); end
      checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL reset_fetch_error: got %b want 0", fetch_error); end
      checks++; if (mem_addr !== 9'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      clear = 1'b0; branch_taken = 1'b1; branch_target = 32'h55; #1;
      checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL idle_branch_ignored: got %b want 0", pc_load); end
      cyc(); branch_taken = 1'b0; #1;
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL idle_no_run: got %b want 0", mem_read); end
   endtask

   task automatic test_basic_fetch();
      restart(32'h0); #1;
      checks++; if (mem_read !== 1'b1 || mem_addr !== 9'h000) begin errors++; $display("FAIL basic_req: read=%b addr=%h want 1/000", mem_read, mem_addr); end
      checks++; if (pc_increment !== 1'b0) begin errors++; $display("FAIL basic_req_inc: got %b want 0", pc_increment); end
      cyc(); mem_ready = 1'b1; mem_data = 32'h1234_5678; #1;
      checks++; if (pc_increment !== 1'b1 || pc_load !== 1'b0) begin errors++; $display("FAIL basic_inc_pulse: inc=%b load=%b want 1/0", pc_increment, pc_load); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", ir_valid); end
      cyc(); mem_ready = 1'b0; mem_data = $urandom; #1;
      checks++; if (ir_valid !== 1'b1 || ir_out !== 32'h1234_5678) begin errors++; $display("FAIL basic_ir: valid=%b ir=%h want 1/12345678", ir_valid, ir_out); end
      checks++; if (pc_increment !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL basic_hold_quiet: inc=%b read=%b want 0/0", pc_increment, mem_read); end
      ir_ack = 1'b1;
      cyc(); ir_ack = 1'b0; #1;
      checks++; if (mem_read !== 1'b1 || mem_addr !== 9'h001 || ir_valid !== 1'b0) begin errors++; $display("FAIL basic_next_req: read=%b addr=%h valid=%b want 1/001/0", mem_read, mem_addr, ir_valid); end
   endtask

   task automatic test_backpressure();
      restart(32'h10);
      cyc(); mem_ready = 1'b1; mem_data = 32'hA5A5_0010;
      cyc(); mem_ready = 1'b0; mem_data = 32'h0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (ir_valid !== 1'b1 || ir_out !== 32'hA5A5_0010 || mem_read !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: valid=%b ir=%h read=%b want 1/a5a50010/0", i, ir_valid, ir_out, mem_read); end
         cyc();
      end
      ir_ack = 1'b1;
      cyc(); ir_ack = 1'b0; #1;
      checks++; if (mem_read !== 1'b1 || mem_addr !== 9'h011) begin errors++; $display("FAIL bp_after_ack: read=%b addr=%h want 1/011", mem_read, mem_addr); end
   endtask

   task automatic test_branch_wait();
      restart(32'h20);
      cyc(); branch_taken = 1'b1; branch_target = 32'h40; #1;
      checks++; if (pc_load !== 1'b1 || pc_target !== 32'h40 || pc_increment !== 1'b0) begin errors++; $display("FAIL bw_load: load=%b tgt=%h inc=%b want 1/40/0", pc_load, pc_target, pc_increment); end
      cyc(); branch_taken = 1'b0; #1;
      checks++; if (mem_read !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL bw_drain: read=%b valid=%b want 0/0", mem_read, ir_valid); end
      cyc(); mem_ready = 1'b1; mem_data = 32'hDEAD_BEEF; #1;
      checks++; if (pc_increment !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL bw_discard: inc=%b valid=%b want 0/0", pc_increment, ir_valid); end
      cyc(); mem_ready = 1'b0; #1;
      checks++; if (ir_valid !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 9'h040) begin errors++; $display("FAIL bw_redirect: valid=%b read=%b addr=%h want 0/1/040", ir_valid, mem_read, mem_addr); end
   endtask

   task automatic test_branch_collide();
      restart(32'h30);
      cyc(); mem_ready = 1'b1; mem_data = 32'hBEEF_0030; branch_taken = 1'b1; branch_target = 32'h40; #1;
      checks++; if (pc_increment !== 1'b0 || pc_load !== 1'b1) begin errors++; $display("FAIL bc_ready: inc=%b load=%b want 0/1", pc_increment, pc_load); end
      cyc(); mem_ready = 1'b0; branch_taken = 1'b0; #1;
      checks++; if (ir_valid !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 9'h040) begin errors++; $display("FAIL bc_ready_next: valid=%b read=%b addr=%h want 0/1/040", ir_valid, mem_read, mem_addr); end
      cyc(); mem_ready = 1'b1; mem_data = 32'h1111_0040;
      cyc(); mem_ready = 1'b0; ir_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; #1;
      checks++; if (ir_valid !== 1'b1 || pc_load !== 1'b1 || pc_increment !== 1'b0) begin errors++; $display("FAIL bc_hold: valid=%b load=%b inc=%b want 1/1/0", ir_valid, pc_load, pc_increment); end
      cyc(); ir_ack = 1'b0; branch_taken = 1'b0; #1;
      checks++; if (ir_valid !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 9'h040) begin errors++; $display("FAIL bc_hold_next: valid=%b read=%b addr=%h want 0/1/040", ir_valid, mem_read, mem_addr); end
   endtask

   task automatic test_wrap_and_clear();
      restart(32'h1FF); #1;
      checks++; if (mem_addr !== 9'h1FF) begin errors++; $display("FAIL wrap_top: got %h want 1ff", mem_addr); end
      cyc(); mem_ready = 1'b1; mem_data = 32'h0000_01FF;
      cyc(); mem_ready = 1'b0; ir_ack = 1'b1;
      cyc(); ir_ack = 1'b0; #1;
      checks++; if (mem_read !== 1'b1 || mem_addr !== 9'h000) begin errors++; $display("FAIL wrap_zero: read=%b addr=%h want 1/000", mem_read, mem_addr); end
      cyc(); #1;
      checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL clr_in_wait: got %b want 1", mem_read); end
      cyc(); clear = 1'b1;
      cyc(); clear = 1'b0; run = 1'b0; mem_ready = 1'b1; mem_data = 32'hFFFF_FFFF; #1;
      checks++; if (mem_read !== 1'b0 || pc_increment !== 1'b0 || pc_load !== 1'b0 || ir_valid !== 1'b0 || ir_out !== 32'd0 || mem_addr !== 9'd0)
         begin errors++; $display("FAIL clr_outputs: read=%b inc=%b load=%b valid=%b ir=%h addr=%h want all 0", mem_read, pc_increment, pc_load, ir_valid, ir_out, mem_addr); end
      cyc(); mem_ready = 1'b0; #1;
      checks++; if (ir_valid !== 1'b0 || ir_out !== 32'd0) begin errors++; $display("FAIL clr_late_ready: valid=%b ir=%h want 0/0", ir_valid, ir_out); end
   endtask

   task automatic test_run_drop();
      restart(32'h60);
      cyc(); run = 1'b0;
      cyc(); mem_ready = 1'b1; mem_data = 32'h0000_600D; #1;
      checks++; if (pc_increment !== 1'b1) begin errors++; $display("FAIL rd_complete: got %b want 1", pc_increment); end
      cyc(); mem_ready = 1'b0; #1;
      checks++; if (ir_valid !== 1'b1 || ir_out !== 32'h0000_600D) begin errors++; $display("FAIL rd_hold: valid=%b ir=%h want 1/0000600d", ir_valid, ir_out); end
      ir_ack = 1'b1;
      cyc(); ir_ack = 1'b0;
      cyc(); #1;
      checks++; if (mem_read !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL rd_idle: read=%b valid=%b want 0/0", mem_read, ir_valid); end
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout();
      restart(32'h70);
      for (int i = 1; i < 16; i++) begin
         cyc(); #1;
         checks++; if (mem_read !== 1'b1 || fetch_error !== 1'b0) begin errors++; $display("FAIL to_wait_%0d: read=%b err=%b want 1/0", i, mem_read, fetch_error); end
      end
      cyc(); #1;
      checks++; if (mem_read !== 1'b0 || pc_increment !== 1'b0) begin errors++; $display("FAIL to_fire: read=%b inc=%b want 0/0", mem_read, pc_increment); end
      cyc(); #1;
      checks++; if (fetch_error !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 9'h070) begin errors++; $display("FAIL to_retry: err=%b read=%b addr=%h want 1/1/070", fetch_error, mem_read, mem_addr); end
      cyc(); mem_ready = 1'b1; mem_data = 32'h7070_7070;
      cyc(); mem_ready = 1'b0; #1;
      checks++; if (ir_valid !== 1'b1 || fetch_error !== 1'b1) begin errors++; $display("FAIL to_sticky: valid=%b err=%b want 1/1", ir_valid, fetch_error); end
      clear = 1'b1;
      cyc(); clear = 1'b0; #1;
      checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", fetch_error); end
   endtask
`else
   task automatic test_timeout();
      restart(32'h70);
      for (int i = 0; i < 40; i++) begin
         cyc(); #1;
         checks++; if (mem_read !== 1'b1 || fetch_error !== 1'b0 || mem_addr !== 9'h070) begin errors++; $display("FAIL nto_wait_%0d: read=%b err=%b addr=%h want 1/0/070", i, mem_read, fetch_error, mem_addr); end
      end
      cyc(); mem_ready = 1'b1; mem_data = 32'h7070_7070;
      cyc(); mem_ready = 1'b0; #1;
      checks++; if (ir_valid !== 1'b1 || ir_out !== 32'h7070_7070) begin errors++; $display("FAIL nto_done: valid=%b ir=%h want 1/70707070", ir_valid, ir_out); end
   endtask
`endif

   // Random traffic: the delivered stream must be consecutive words from memory, restarting at each redirect.
   task automatic test_random();
      bit          pending = 1'b0;
      logic [8:0]  paddr = 9'd0;
      int          delay = 0;
      logic [31:0] exp_addr = 32'h1F8;
      logic [31:0] prev_ir = 32'd0;
      bit          prev_hold = 1'b0;
      int          deliveries = 0;
      restart(32'h1F8);
      for (int n = 0; n < 2500; n++) begin
         if (n > 0) cyc();
         branch_taken = 1'b0;
         ir_ack       = ($urandom_range(0, 2) != 0);
         mem_ready    = pending && (delay == 0);
         mem_data     = mem_ready ? memf(paddr) : $urandom;
         #1;
         if ((mem_read || ir_valid) && $urandom_range(0, 7) == 0) begin
            branch_taken  = 1'b1;
            branch_target = $urandom_range(0, 1023);
         end
         #1;
         checks++; if (pc_load !== branch_taken) begin errors++; $display("FAIL rnd_load: cyc %0d got %b want %b", n, pc_load, branch_taken); end
         checks++; if (pc_increment === 1'b1 && (pc_load !== 1'b0 || mem_ready !== 1'b1)) begin errors++; $display("FAIL rnd_inc: cyc %0d inc=%b load=%b ready=%b", n, pc_increment, pc_load, mem_ready); end
         if (prev_hold) begin
            checks++; if (ir_valid !== 1'b1 || ir_out !== prev_ir) begin errors++; $display("FAIL rnd_stable: cyc %0d valid=%b ir=%h want 1/%h", n, ir_valid, ir_out, prev_ir); end
         end
         if (ir_valid && ir_ack && !branch_taken) begin
            checks++; if (ir_out !== memf(exp_addr[8:0])) begin errors++; $display("FAIL rnd_deliver: cyc %0d ir=%h want %h (addr %h)", n, ir_out, memf(exp_addr[8:0]), exp_addr); end
            exp_addr = exp_addr + 32'd1;
            deliveries++;
         end
         if (branch_taken) exp_addr = branch_target;
         if (mem_ready) pending = 1'b0;
         else if (pending) delay--;
         else if (mem_read) begin pending = 1'b1; paddr = mem_addr; delay = $urandom_range(0, 3); end
         prev_hold = ir_valid && !ir_ack && !branch_taken;
         prev_ir   = ir_out;
      end
      checks++; if (deliveries < 100) begin errors++; $display("FAIL rnd_progress: got %0d deliveries want >= 100", deliveries); end
      cyc(); branch_taken = 1'b0; ir_ack = 1'b0; mem_ready = 1'b0;
   endtask

   initial begin
      clear = 1'b1; run = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
      mem_ready = 1'b0; mem_data = 32'd0; ir_ack = 1'b0;
      test_reset();
      test_basic_fetch();
      test_backpressure();
      test_branch_wait();
      test_branch_collide();
      test_wrap_and_clear();
      test_run_drop();
      test_timeout();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
